uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter between four byte-wide requesters.
- Each cycle in IDLE it picks a pending requester using round-robin order, latches that requester's byte, and issues a one-cycle write pulse.
- It holds the data stable for the whole frame and waits for the transmitter's busy signal to rise and then fall before the next grant.
- It sits between client logic (command/status sources) and the transmitter, driving the transmitter's Tx_DATA, Tx_WR and Tx_EN and watching Tx_BUSY.

Parameters:
- TIMEOUT, 16: maximum cycles in WAIT_BUSY without tx_busy before the frame is abandoned.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- arb_en  input  1  level; allows new grants when high
- req  input  4  per-requester request, level, held until its ack
- req_data  input  32  requester i byte on bits [8i+7:8i]; valid while req[i] is high
- req_ack  output  4  one-hot, one-cycle pulse; requester i may drop req[i] and change its data after this pulse
- tx_data  output  8  to transmitter Tx_DATA; held constant from ISSUE through WAIT_DONE
- tx_wr  output  1  to transmitter Tx_WR; one-cycle pulse
- tx_en  output  1  to transmitter Tx_EN
- tx_busy  input  1  from transmitter Tx_BUSY
- grant_id  output  2  index of the requester currently or last served
- arb_busy  output  1  high in every state except IDLE
- frame_done  output  1  one-cycle pulse when tx_busy falls
- err_timeout  output  1  sticky timeout flag
- err_clr  input  1  synchronous clear of err_timeout

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, req_ack=0, tx_data=0, tx_wr=0, tx_en=0, grant_id=0, arb_busy=0, frame_done=0, err_timeout=0. The internal last-grant pointer resets to 3, so requester 0 is served first.
- State IDLE:
  - If arb_en is high and req is nonzero, select the first set req[i] searching last+1, last+2, last+3, last (mod 4).
  - On that edge: tx_data <= req_data byte i, req_ack[i] <= 1, tx_wr <= 1, tx_en <= 1, grant_id <= i, last <= i, go to ISSUE.
  - Otherwise stay in IDLE with tx_en=0.
- State ISSUE (one cycle; req_ack and tx_wr are visible this cycle):
  - Next edge clears req_ack and tx_wr, clears the timeout counter, and goes to WAIT_BUSY.
  - The transmitter samples Tx_WR at this same edge.
- State WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Else increment the counter. On the cycle where counter == TIMEOUT-1 with tx_busy still 0: set err_timeout, tx_en <= 0, go to IDLE. The byte is dropped, last keeps i, and no frame_done is issued.
- State WAIT_DONE:
  - When tx_busy=0: frame_done <= 1 for one cycle, tx_en <= 0, go to IDLE.
  - tx_data stays unchanged throughout, because the transmitter reads it combinationally per bit.
- Latency: req seen in IDLE at cycle n gives ack and tx_wr in cycle n+1, and the transmitter's busy rises in cycle n+2.
- At least one IDLE cycle separates consecutive frames: grants are only evaluated in IDLE.
- arb_en is sampled only in IDLE. Dropping it mid-frame does not abort the frame; tx_en stays high until the frame completes.
- A req deasserted before its ack is simply not granted. There is no partial handshake.
- err_clr clears err_timeout. If err_clr and a new timeout occur in the same cycle, set wins.
- Reset mid-frame returns to IDLE immediately with all outputs at reset values. The transmitter shares this reset.

Optional Feature:
- Macro UART_TX_ARB_FIXED_PRIO_EN.
- Defined: selection is fixed priority, lowest index wins (req[0] highest), and the last pointer is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single requester: req=0001, data 0xA5, arb_en=1.
  - req_ack=0001 and tx_wr pulse in the same cycle, tx_data=0xA5 held until frame_done.
  - Connected transmitter emits start bit, bits 1,0,1,0,0,1,0,1 (MSB first), parity 0, stop bit.
- Round-robin: req=1111 held with auto re-raise, bytes 0x10/0x21/0x32/0x43.
  - Grant order 0,1,2,3,0, one frame_done per grant, exactly one IDLE cycle between frames.
- arb_en=0 with req=0100 for 50 cycles gives no ack and tx_en=0. Setting arb_en=1 gives ack=0100 on the next cycle.
- Timeout: tx_busy tied to 0, req=0010.
  - err_timeout rises 16 cycles after the ISSUE cycle, state returns to IDLE, no frame_done.
  - err_clr pulse clears the flag.
- Reset asserted mid-frame (in WAIT_DONE) gives all outputs at reset values within the same cycle. The next req=0001 is granted normally.
- Fixed-priority build (macro defined): req=1111 held gives requester 0 granted every frame.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between four byte-wide requesters.
// A grant latches the requester's byte and pulses Tx_WR.
// The byte is then held while the transmitter's busy signal rises and falls.
// A frame is abandoned if busy never rises within TIMEOUT cycles.
// Build option UART_TX_ARB_FIXED_PRIO_EN selects fixed priority (req[0] highest)
// instead of the default round-robin.
module uart_tx_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        arb_en,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ack,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   output logic        tx_en,
   input  logic        tx_busy,
   output logic [1:0]  grant_id,
   output logic        arb_busy,
   output logic        frame_done,
   output logic        err_timeout,
   input  logic        err_clr
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         req_ack_q, req_ack_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_wr_q, tx_wr_d;
   logic               tx_en_q, tx_en_d;
   logic [1:0]         grant_q, grant_d;
   logic               arb_busy_q, arb_busy_d;
   logic               frame_done_q, frame_done_d;
   logic               err_q, err_d;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
`else
   logic [1:0]         last_q, last_d;
   logic [1:0]         cand;
`endif

   logic               sel_valid;
   logic [1:0]         sel_idx;
   logic               grant_now;
   logic               timeout_hit;

   // Pick the requester to serve if a grant happens this cycle
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      sel_valid = 1'b0;
      sel_idx   = 2'd0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      // Scan high to low so the lowest set index is the last writer and wins.
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) begin
            sel_valid = 1'b1;
            sel_idx   = 2'(i);
         end
      end
`else
      cand = 2'd0;
      // Scan from the farthest candidate (last itself) to the nearest (last+1)
      // so the first one after the previous grant is the last writer and wins.
      for (int k = 4; k >= 1; k--) begin
         cand = last_q + 2'(k);
         if (req[cand]) begin
            sel_valid = 1'b1;
            sel_idx   = cand;
         end
      end
`endif
   end

   assign grant_now   = (state_q == IDLE) && arb_en && sel_valid;
   assign timeout_hit = (state_q == WAIT_BUSY) && !tx_busy &&
                        (cnt_q == CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (grant_now) state_d = ISSUE;
         ISSUE:     state_d = WAIT_BUSY;
         WAIT_BUSY: begin
            if (tx_busy)          state_d = WAIT_DONE;
            else if (timeout_hit) state_d = IDLE;
         end
         WAIT_DONE: if (!tx_busy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs, counter and grant pointer
   always_comb begin
      req_ack_d    = 4'b0000;
      tx_wr_d      = 1'b0;
      frame_done_d = 1'b0;
      tx_data_d    = tx_data_q;
      tx_en_d      = tx_en_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      arb_busy_d   = (state_d != IDLE);
      // A timeout in the same cycle overrides the clear below.
      err_d        = err_clr ? 1'b0 : err_q;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
`else
      last_d       = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_now) begin
               tx_data_d          = req_data[8*sel_idx +: 8];
               req_ack_d[sel_idx] = 1'b1;
               tx_wr_d            = 1'b1;
               tx_en_d            = 1'b1;
               grant_d            = sel_idx;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
`else
               last_d             = sel_idx;
`endif
            end else begin
               tx_en_d = 1'b0;
            end
         end
         ISSUE: cnt_d = '0;
         WAIT_BUSY: begin
            if (timeout_hit) begin
               err_d   = 1'b1;
               tx_en_d = 1'b0;
            end else if (!tx_busy) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               frame_done_d = 1'b1;
               tx_en_d      = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Output, counter and pointer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_ack_q    <= 4'b0000;
         tx_data_q    <= 8'h00;
         tx_wr_q      <= 1'b0;
         tx_en_q      <= 1'b0;
         grant_q      <= 2'd0;
         arb_busy_q   <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
`else
         // Pointer starts at 3 so requester 0 is the first candidate.
         last_q       <= 2'd3;
`endif
      end else begin
         req_ack_q    <= req_ack_d;
         tx_data_q    <= tx_data_d;
         tx_wr_q      <= tx_wr_d;
         tx_en_q      <= tx_en_d;
         grant_q      <= grant_d;
         arb_busy_q   <= arb_busy_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
`else
         last_q       <= last_d;
`endif
      end
   end

   assign req_ack     = req_ack_q;
   assign tx_data     = tx_data_q;
   assign tx_wr       = tx_wr_q;
   assign tx_en       = tx_en_q;
   assign grant_id    = grant_q;
   assign arb_busy    = arb_busy_q;
   assign frame_done  = frame_done_q;
   assign err_timeout = err_q;

endmodule
